// File: rtl/kgp_mem_pkg.sv
// kgp_mem_pkg: shared FSM states, width/latency defaults and the byte-to-word
// address helper for the KGP-RISC data-memory access path.
package kgp_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction
endpackage

// File: rtl/mem_lat_cnt.sv
// mem_lat_cnt: loadable down-counter with zero flag, used to wait out the
// data-memory read latency.
module mem_lat_cnt
    import kgp_mem_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store handshake bridge between execute, data memory and writeback.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests respond with rsp_err instead of accessing memory.
module mem_access_ctrl
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_is_load,
    output logic              rsp_err
);
    state_t state, state_nx;
    logic we_q, mis, lat_zero, accept;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign mis = req_addr[1:0] != 2'b00;
`else
    assign mis = 1'b0;
`endif
    assign accept = state == IDLE && req_valid;
    mem_lat_cnt u_lat (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ACCESS),
        .dec     (state == WAIT),
        .load_val(LAT_CNT_W'(RD_LAT - RD_LAT_MIN)),
        .zero    (lat_zero)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data    <= '0;
            rsp_rd      <= '0;
            rsp_is_load <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q        <= req_we;
                addr_q      <= ADDR_W'(byte_to_word(req_addr));
                wdata_q     <= req_wdata;
                rsp_data    <= '0;
                rsp_rd      <= req_rd;
                rsp_is_load <= !req_we;
                rsp_err     <= mis;
            end else if (state == WAIT && lat_zero) begin
                rsp_data <= mem_rdata;
            end
        end
    end
    // memory strobes are purely a function of the ACCESS state, so reset drops them at once
    always_comb begin
        state_nx  = state;
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        mem_read  = state == ACCESS && !we_q;
        mem_write = state == ACCESS && we_q;
        mem_addr  = state == ACCESS ? addr_q : '0;
        mem_wdata = mem_write ? wdata_q : '0;
        case (state)
            IDLE:    state_nx = req_valid ? (mis ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = we_q ? RESP : WAIT;
            WAIT:    state_nx = lat_zero ? RESP : WAIT;
            default: state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access controller between the execute stage and the data memory of the KGP-RISC core. It accepts one load or store request per transaction via a valid/ready handshake and converts the 32-bit ALU byte address to a 10-bit word address. It drives single-cycle read/write strobes to the data memory and waits out the memory's synchronous read latency. It then returns load data (or store completion) to the writeback stage through a second valid/ready handshake.

## Interface
- ADDR_W, 10, data-memory word-address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from strobe edge to valid `mem_rdata`; legal range 1..4
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data
- req_rd  in  5  destination register for loads
- mem_addr  out  ADDR_W  word address to data memory
- mem_wdata  out  DATA_W  write data to data memory
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_rdata  in  DATA_W  read data from data memory
- rsp_valid  out  1  response available
- rsp_ready  in  1  writeback stage accepts response
- rsp_data  out  DATA_W  load data; 0 for stores
- rsp_rd  out  5  destination register, copied from request
- rsp_is_load  out  1  1 = response is a load
- rsp_err  out  1  misaligned access flag; see Configuration

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1. If req_valid=1, register we/addr/wdata/rd and go to ACCESS.
- req_ready=0 in all other states. Upstream holds its request stable until the handshake completes.
- ACCESS lasts exactly one cycle.
  - mem_addr = req_addr[ADDR_W+1:2].
  - Load: mem_read=1. Store: mem_write=1 and mem_wdata = registered wdata.
  - Next state: WAIT for a load, RESP for a store.
- WAIT: a down-counter is loaded with RD_LAT-1. On the cycle the counter reads 0, `mem_rdata` is captured into rsp_data and the state goes to RESP.
- RESP: rsp_valid=1, held with stable data until rsp_ready=1. Then go to IDLE.
  - Stores respond too, with rsp_is_load=0 and rsp_data=0, so that retirement stays in order.
- Outside ACCESS: mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
- req_addr[31:ADDR_W+2] are ignored; addresses wrap modulo 4 KiB.
- A req_valid asserted during RESP is ignored until IDLE; there is no back-to-back overlap.

## Timing
- Reset values, applied asynchronously the moment rst falls:
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_is_load=0, rsp_err=0.
  - All mem_* outputs 0.
- Reset mid-transaction aborts the transaction. Strobes drop immediately and no response is issued.
- Load: request accepted at edge E0. Strobe high during cycle E0→E1. rsp_valid rises at edge E(1+RD_LAT).
- Store: rsp_valid rises at E1.
- Minimum transaction length, including the return to IDLE: load 3+RD_LAT cycles, store 3 cycles.
- Strobes are never high for more than one cycle per request.

## Configuration
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0]≠0 skips ACCESS/WAIT and goes straight to RESP with rsp_err=1 and rsp_data=0. No memory strobe is issued. rsp_valid rises at E1.
- Undefined: req_addr[1:0] are ignored and rsp_err is tied to 0.

## Structure
- Shared package kgp_mem_pkg holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP);
  - the ADDR_W/DATA_W defaults and the RD_LAT range constants;
  - a byte-to-word address function.
- One sub-module, mem_lat_cnt: a loadable down-counter with a zero flag, width sized for RD_LAT ≤ 4.

## Test plan
- Reset during WAIT of a load to address 0x010 → all outputs return to reset values at once; no rsp_valid; req_ready=1.
- Store of 0xDEADBEEF to byte address 0x024 → mem_write=1 for exactly one cycle with mem_addr=9 and mem_wdata=0xDEADBEEF; rsp_valid at E1 with rsp_is_load=0.
- Load from 0x024 after that store, RD_LAT=1 and RD_LAT=3 → mem_read=1 for one cycle with mem_addr=9; rsp_data=0xDEADBEEF and rsp_rd echoed; rsp_valid at E2 and E4 respectively.
- rsp_ready held low for 5 cycles on a load → rsp_valid and rsp_data stable throughout; req_ready stays 0; a new req_valid is not accepted until after the rsp handshake.
- Load from 0x026 with MEM_ALIGN_CHECK_EN → no strobe, rsp_err=1, rsp_data=0. Without the macro → mem_addr=9, rsp_err=0.
- Address 0x1024 → mem_addr=9 (wrap-around).
